rca_chunk_sequencer: RTL and testbench
======================================

// Module: rca_chunk_sequencer
// PURPOSE
//  - Multi-cycle wide adder that slices WIDTH-bit operands into 4-bit chunks.
//  - Feeds one chunk per cycle, LSB first, to a single rca_4bit instance.
//  - Registers the carry between chunks.
//  - Sits directly upstream of rca_4bit: owns operand sequencing, carry chaining
//    and result assembly, so wide additions reuse one 4-bit adder.
// PARAMETERS
//  - WIDTH   16   operand/result width; must be a multiple of 4 and >= 8
//  - NCHUNK  WIDTH/4   derived (localparam); number of chunk cycles
// PORTS
//  - clk     in   1      single clock; all state updates on rising edge
//  - rst     in   1      synchronous, active-high reset
//  - start   in   1      request; accepted only on an edge where busy==0
//  - a       in   WIDTH  operand A; sampled on the accepting edge only
//  - b       in   WIDTH  operand B; sampled on the accepting edge only
//  - cin     in   1      carry-in; sampled on the accepting edge only
//  - busy    out  1      high while a sum is in progress (RUN state)
//  - done    out  1      one-cycle pulse: sum/cout valid and newly updated
//  - sum     out  WIDTH  final result, held until the next completion
//  - cout    out  1      final carry-out, held until the next completion
// BEHAVIOUR
//  - Reset (rst==1 on an edge): state=IDLE, idx=0, carry=0.
//    busy=0, done=0, sum=0, cout=0. Internal operand/partial regs are cleared.
//  - States: IDLE, RUN, DONE.
//    - IDLE: start==1 latches a, b and cin (carry<=cin), sets idx<=0, goes to RUN.
//    - RUN: on each edge, chunk idx of A/B plus carry goes to rca_4bit.
//      Chunk sum is written to partial[4*idx +: 4]; carry<=rca cout; idx<=idx+1.
//    - RUN, idx==NCHUNK-1 edge: sum<={chunk, partial lower bits}, cout<=rca cout,
//      go to DONE.
//    - DONE: done=1 for exactly this cycle.
//      start==1 is accepted here (same as IDLE: go to RUN); otherwise go to IDLE.
//  - busy=1 only in RUN; done=1 only in DONE. Both are decoded from registered state.
//  - Latency: start accepted at edge E -> done high in the cycle after edge E+NCHUNK.
//    For WIDTH=16 that is 5 edges including E.
//    Throughput: one result per NCHUNK+1 cycles with back-to-back starts.
//  - start while busy==1 is ignored; it is not queued and does not disturb the run.
//  - Changes on a/b/cin after acceptance have no effect on the run in progress.
//  - sum/cout never show partial results; they change only on the final RUN edge.
//  - Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); unsigned.
//    Wrap-around produces cout=1.
//  - rst during RUN or DONE: abort immediately to reset values.
//    No done pulse; the previous sum/cout are lost (cleared to 0).
//  - rst and start on the same edge: rst wins; start is dropped.
//  - idx width = $clog2(NCHUNK). Its final value is never NCHUNK, so no counter wrap.
// STRUCTURE
//  - Shared package: CHUNK_W=4; state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//    Include a WIDTH % CHUNK_W check macro or function for elaboration-time assert.
//  - Sub-module: one rca_4bit instance.
//    Inputs: the muxed operand chunks and the carry register.
//    Outputs: chunk sum and chunk cout.
//  - Everything else lives in this module: FSM, idx counter, operand/partial regs,
//    output regs.
// TESTING  (WIDTH=16; check busy/done timing every cycle, compare against a+b+cin)
//  - 0x1234 + 0x4321, cin=0 -> done 5 edges after start; sum=0x5555, cout=0;
//    busy high for exactly 4 cycles.
//  - 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1 (full carry ripple across all chunks).
//  - 0x8000 + 0x8000, cin=1 -> sum=0x0001, cout=1.
//    Then start pulsed during busy with other operands -> ignored, result unchanged.
//  - Back-to-back: start held high.
//    0x00FF+0x0001 then 0x0F0F+0xF0F0 (cin=1) -> done pulses 5 cycles apart;
//    sum=0x0100/cout=0, then sum=0x0000/cout=1.
//  - rst asserted on the 2nd RUN edge of 0xAAAA+0x5555 -> busy=0, no done,
//    sum=0, cout=0. A fresh start of 0x0001+0x0001 then gives sum=0x0002.
//  - Random: 1000 operand/cin triples with random start gaps -> every done matches
//    the a+b+cin model; sum/cout stable between done pulses.

Source files
------------

// File: rtl/rca_chunk_sequencer_pkg.sv
// rtl/rca_chunk_sequencer_pkg.sv - shared chunk width, state encoding and width check
package rca_chunk_sequencer_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operands must split into whole chunks and need at least two of them.
    function automatic bit width_ok(input int w);
        return ((w % CHUNK_W) == 0) && (w >= 2 * CHUNK_W);
    endfunction

endpackage

// File: rtl/rca_4bit.sv
// rtl/rca_4bit.sv - 4-bit ripple-carry adder used once per chunk cycle
module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/rca_chunk_sequencer.sv
// rtl/rca_chunk_sequencer.sv - wide adder sequencing 4-bit chunks LSB first through one rca_4bit
module rca_chunk_sequencer
    import rca_chunk_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = $clog2(NCHUNK);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("rca_chunk_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   partial;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] chunk_sum;
    logic               chunk_cout;
    logic               last_chunk;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) begin
                a_chunk = a_r[i*CHUNK_W +: CHUNK_W];
                b_chunk = b_r[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

    rca_4bit u_rca (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            partial <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx == IDX_W'(i)) partial[i*CHUNK_W +: CHUNK_W] <= chunk_sum;
                    end
                    carry <= chunk_cout;
                    if (last_chunk) begin
                        // The top chunk goes straight into sum; partial only holds the lower chunks.
                        sum   <= {chunk_sum, partial[WIDTH-CHUNK_W-1:0]};
                        cout  <= chunk_cout;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rca_chunk_sequencer.sv
// tb/tb_rca_chunk_sequencer.sv - scoreboard bench for rca_chunk_sequencer, WIDTH=16
module tb_rca_chunk_sequencer;

    localparam int WIDTH  = 16;
    localparam int NCHUNK = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];

    logic [WIDTH-1:0] held_sum = '0;
    logic             held_cout = 1'b0;
    int               run_len = 0;

    rca_chunk_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            held_sum  = '0;
            held_cout = 1'b0;
            run_len   = 0;
            check(busy == 1'b0, "reset_busy", busy, 0);
            check(done == 1'b0, "reset_done", done, 0);
            check(sum == '0, "reset_sum", sum, 0);
            check(cout == 1'b0, "reset_cout", cout, 0);
        end else begin
            if (busy) begin
                run_len++;
            end else if (run_len != 0) begin
                check(run_len == NCHUNK, "busy_length", run_len, NCHUNK);
                run_len = 0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_done", 1, 0);
                end else begin
                    logic [WIDTH:0] e;
                    int             acc;
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check(sum == e[WIDTH-1:0], "sum", sum, e[WIDTH-1:0]);
                    check(cout == e[WIDTH], "cout", cout, e[WIDTH]);
                    check(cyc - acc == NCHUNK, "latency", cyc - acc, NCHUNK);
                end
                held_sum  = sum;
                held_cout = cout;
            end else begin
                check(sum == held_sum, "sum_stable", sum, held_sum);
                check(cout == held_cout, "cout_stable", cout, held_cout);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        if (busy) check(1'b0, "idle_timeout", 1, 0);
    endtask

    task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                         input logic [WIDTH:0] e);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
    endtask

    task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                         input logic [WIDTH:0] e);
        @(negedge clk);
        wait_idle();
        drive(va, vb, vc, e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h1234, 16'h4321, 1'b0, 17'h0_5555);
        issue(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
        issue(16'h8000, 16'h8000, 1'b1, 17'h1_0001);

        // Start pulsed during the run with other operands must be ignored.
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;

        // Back-to-back with start held high.
        @(negedge clk);
        wait_idle();
        drive(16'h00FF, 16'h0001, 1'b0, 17'h0_0100);
        @(negedge clk);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        if (!done) check(1'b0, "b2b_done_timeout", 0, 1);
        drive(16'h0F0F, 16'hF0F0, 1'b1, 17'h1_0000);
        @(negedge clk);
        start = 1'b0;

        // Reset on the second RUN edge aborts the add.
        @(negedge clk);
        wait_idle();
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(busy == 1'b0, "abort_busy", busy, 0);
        check(sum == '0, "abort_sum", sum, 0);
        check(cout == 1'b0, "abort_cout", cout, 0);
        repeat (6) @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 17'h0_0002);

        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(1));
            repeat ($urandom_range(3)) @(negedge clk);
            issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'b0, rc});
        end

        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
